left_shift_deser_rx: RTL
========================

// Module: left_shift_deser_rx
// PURPOSE
//  Receive end of the left-shift serial link. Collects DW serial bits, MSB first, into a parallel word.
//  The bits arrive on data_s, qualified by en, from a left-shift transmitter that shifts out q[DW-1] first.
//  Each completed word goes to an output holding register with a valid/ready handshake.
//  Flags overrun when a word completes while the holding register is still full.
// PARAMETERS
//  DW  4  word width in bits (>=2)
//  CW  derived localparam = $clog2(DW); width of bit_cnt
// PORTS
//  clk         in   1     rising-edge clock; single clock domain
//  sync_rst_n  in   1     reset; synchronous, active-low
//  clr         in   1     sync frame restart; discards any partial word
//  en          in   1     serial bit strobe; data_s sampled when en=1
//  data_s      in   1     serial data, MSB first
//  q_ready     in   1     consumer accepts q this cycle when q_valid=1
//  q           out  DW    received word (registered)
//  q_valid     out  1     q holds an unconsumed word
//  overrun     out  1     sticky: a completed word was dropped
//  busy        out  1     partial frame in progress (bit_cnt!=0)
//  bit_cnt     out  CW    bits received in current frame, 0..DW-1
// BEHAVIOUR
//  Reset (sync_rst_n=0 at posedge):
//   - sr, q, bit_cnt = 0; q_valid = 0; overrun = 0. Reset overrides all other inputs.
//  Priority per edge: reset > clr > en.
//  clr=1:
//   - sr = 0, bit_cnt = 0, overrun = 0.
//   - q and q_valid unchanged; q_ready handshake still honoured.
//   - any en in the same cycle is ignored.
//  en=1, clr=0:
//   - sr <= {sr[DW-2:0], data_s}.
//   - bit_cnt increments; wraps DW-1 -> 0.
//  Completion: en=1 while bit_cnt==DW-1; word w = {sr[DW-2:0], data_s}.
//   - If q_valid=0 or q_ready=1: q <= w, q_valid <= 1.
//   - Else: w dropped, q unchanged, overrun <= 1.
//  Latency: q/q_valid update on the edge that samples the DW-th bit; visible the following cycle.
//  Consume: q_valid & q_ready with no completion -> q_valid <= 0. q keeps its value.
//  Completion and consume in the same cycle:
//   - q replaced, q_valid stays 1, no overrun.
//   - No bubble: back-to-back words at en=1 every cycle are lossless while q_ready=1.
//  en=0: sr and bit_cnt hold. Gaps between bits are legal and unbounded.
//  busy = (bit_cnt != 0), decoded from the register; no combinational path from inputs.
//  overrun clears only on clr or reset.
// STRUCTURE
//  Shared include/package: CW derivation function (clog2); no other typedefs.
//  One sub-module: mod_n_counter #(N=DW)
//   - inputs: clk, sync_rst_n, clr, inc.
//   - outputs: cnt, wrap (inc & cnt==N-1).
//  Top-level logic: shift register sr[DW-1:0], holding register q, and the q_valid/overrun logic.
// TESTING (DW=4; check every cycle against a bit-level reference model)
//  1. Reset:
//     - Stimulus: sync_rst_n=0 for 2 cycles with en=1, data_s=1.
//     - Response: q=0, q_valid=0, overrun=0, bit_cnt=0, busy=0.
//  2. Basic frame:
//     - Stimulus: q_ready=1; bits 1,0,1,1 on 4 consecutive en cycles.
//     - Response: next cycle q=4'b1011, q_valid=1 for exactly 1 cycle.
//  3. Gapped bits:
//     - Stimulus: bits 0,1,1,0 with en idle 3 cycles between each.
//     - Response: bit_cnt holds during gaps; q=4'b0110.
//  4. Backpressure/overrun:
//     - Stimulus: q_ready=0; words 1010 then 0101.
//     - Response: q stays 1010, overrun=1 after the 8th bit.
//     - Then q_ready=1 for 1 cycle: q_valid=0, overrun stays 1.
//  5. Same-cycle consume:
//     - Stimulus: q_valid=1, q_ready=1 on the completing edge of 1100.
//     - Response: q=1100, q_valid stays 1, overrun=0; 3 back-to-back words all delivered.
//  6. Mid-frame abort:
//     - a) 2 bits, then clr together with en: bit_cnt=0 and that bit is ignored; next 4 bits 1001 give q=1001.
//     - b) Repeat with sync_rst_n=0 mid-frame: all outputs 0.

Source files
------------

// File: rtl/left_shift_deser_rx_pkg.sv
// Shared helpers for the left-shift serial receiver: width derivation for the bit counter.
package left_shift_deser_rx_pkg;

  // Smallest r with 2**r >= v; evaluated at elaboration to size counters.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/left_shift_deser_rx_mod_n_counter.sv
// Modulo-N event counter with synchronous clear; wrap flags the increment that returns to zero.
module mod_n_counter
  import left_shift_deser_rx_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         sync_rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic at_top;
  assign at_top = (cnt == W'(N - 1));
  assign wrap   = inc && at_top;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!sync_rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= at_top ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/left_shift_deser_rx.sv
// Left-shift serial receiver: assembles DW bits MSB first and hands each word to a valid/ready holding register.
module left_shift_deser_rx
  import left_shift_deser_rx_pkg::*;
#(
  parameter  int DW = 4,
  localparam int CW = clog2(DW)
) (
  input  logic          clk,
  input  logic          sync_rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          data_s,
  input  logic          q_ready,
  output logic [DW-1:0] q,
  output logic          q_valid,
  output logic          overrun,
  output logic          busy,
  output logic [CW-1:0] bit_cnt
);

  logic [DW-1:0] sr;
  logic [DW-1:0] word;
  logic          shift;
  logic          complete;
  logic          consume;

  // clr wins over en, so a bit arriving alongside clr never reaches the counter or shifter.
  assign shift   = en && !clr;
  assign word    = {sr[DW-2:0], data_s};
  assign consume = q_valid && q_ready;

  mod_n_counter #(.N(DW)) u_bit_cnt (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .clr        (clr),
    .inc        (shift),
    .cnt        (bit_cnt),
    .wrap       (complete)
  );

  assign busy = (bit_cnt != '0);

  // NOTE: every register here has a defined reset value, including the data path (q, sr).
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      sr      <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (clr)
        sr <= '0;
      else if (shift)
        sr <= word;

      // A completion may land while the consumer drains the old word: replace without a bubble.
      if (complete && (!q_valid || q_ready)) begin
        q       <= word;
        q_valid <= 1'b1;
      end else if (consume) begin
        q_valid <= 1'b0;
      end

      if (clr)
        overrun <= 1'b0;
      else if (complete && q_valid && !q_ready)
        overrun <= 1'b1;
    end
  end

endmodule
